pipe_flow_ctrl: RTL and testbench

Central flow controller for the five-stage P7 pipeline. It generates the stall and bubble controls from Tuse/Tnew hazard comparison and from multiply/divide unit occupancy. It also sequences exception/interrupt entry and eret return, driving the `req` flush into every pipeline register (F/D, D/E, E/M, M/WB) and the next-PC redirect. It sits beside the pipeline registers and has no datapath of its own beyond a latency counter and a small FSM.

---
 rtl/pipe_flow_ctrl_pkg.sv | 30 +++
 rtl/pipe_flow_ctrl_md_busy_cnt.sv | 26 ++
 rtl/pipe_flow_ctrl.sv | 63 ++++++
 tb/tb_pipe_flow_ctrl.sv | 160 ++++++++++++++++
 4 files changed

// File: rtl/pipe_flow_ctrl_pkg.sv
// pipe_flow_ctrl_pkg: shared encodings, latencies and hazard helper for the P7 flow controller
package pipe_flow_ctrl_pkg;
  localparam int T_W = 2;
  localparam logic [T_W-1:0] T_UNUSED = 2'd3;
  localparam logic [31:0] HANDLER_PC = 32'h0000_4180;
  localparam logic [31:0] RESET_PC = 32'h0000_3000;
  localparam int MULT_LAT = 5;
  localparam int DIV_LAT = 10;
  localparam int CNT_W = 4;
  typedef enum logic [1:0] {
    NPC_NORMAL  = 2'b00,
    NPC_HANDLER = 2'b01,
    NPC_EPC     = 2'b10
  } npc_sel_e;
  typedef enum logic {
    RUN,
    EXC_HOLD
  } state_e;
  // A source stalls when a younger-than-needed result is still in flight in E or M.
  function automatic logic hz_src(
    input logic [4:0]     d,
    input logic [T_W-1:0] tuse,
    input logic [4:0]     e_a3,
    input logic [T_W-1:0] e_tnew,
    input logic [4:0]     m_a3,
    input logic [T_W-1:0] m_tnew
  );
    return (d != 5'd0) & (((d == e_a3) & (e_tnew > tuse)) | ((d == m_a3) & (m_tnew > tuse)));
  endfunction
endpackage

// File: rtl/pipe_flow_ctrl_md_busy_cnt.sv
// md_busy_cnt: multiply/divide occupancy counter with busy decode
module md_busy_cnt
  import pipe_flow_ctrl_pkg::*;
#(
  parameter int P_MULT_LAT = MULT_LAT,
  parameter int P_DIV_LAT  = DIV_LAT,
  parameter int P_CNT_W    = CNT_W
) (
  input  logic clk,
  input  logic reset,
  input  logic i_start,
  input  logic i_op,
  input  logic i_req,
  output logic o_busy
);
  logic [P_CNT_W-1:0] r_cnt;
  always_ff @(posedge clk) begin
    if (reset) r_cnt <= '0;
    else if (i_start & ~i_req & (r_cnt == '0)) r_cnt <= i_op ? P_CNT_W'(P_DIV_LAT) : P_CNT_W'(P_MULT_LAT);
    else if (r_cnt != '0) r_cnt <= r_cnt - P_CNT_W'(1);
  end
  assign o_busy = (r_cnt != '0);
  // A second start while occupied is dropped by the counter; flag it as a protocol error.
  assert property (@(posedge clk) disable iff (reset) !(i_start && o_busy))
    else $error("md_busy_cnt: start issued while MDU busy");
endmodule

// File: rtl/pipe_flow_ctrl.sv
// pipe_flow_ctrl: stall/bubble, exception entry and eret redirect control for the P7 pipeline
module pipe_flow_ctrl
  import pipe_flow_ctrl_pkg::*;
#(
  parameter logic [31:0] P_HANDLER_PC = HANDLER_PC,
  parameter int          P_MULT_LAT   = MULT_LAT,
  parameter int          P_DIV_LAT    = DIV_LAT,
  parameter int          P_CNT_W      = CNT_W
) (
  input  logic           clk,
  input  logic           reset,
  input  logic [4:0]     i_d_rs,
  input  logic [4:0]     i_d_rt,
  input  logic [T_W-1:0] i_d_tuse_rs,
  input  logic [T_W-1:0] i_d_tuse_rt,
  input  logic           i_d_is_md,
  input  logic [4:0]     i_e_a3,
  input  logic [T_W-1:0] i_e_tnew,
  input  logic [4:0]     i_m_a3,
  input  logic [T_W-1:0] i_m_tnew,
  input  logic           i_e_md_start,
  input  logic           i_e_md_op,
  input  logic           i_m_exc,
  input  logic           i_m_eret,
  input  logic [31:0]    i_epc,
  output logic           o_stall,
  output logic           o_req,
  output logic           o_eret_flush,
  output logic [1:0]     o_npc_sel,
  output logic [31:0]    o_redirect_pc,
  output logic           o_md_busy
);
  state_e r_state, w_next;
  logic   w_req, w_eret, w_busy, w_hz;
  always_ff @(posedge clk) r_state <= reset ? RUN : w_next;
  md_busy_cnt #(
    .P_MULT_LAT(P_MULT_LAT),
    .P_DIV_LAT (P_DIV_LAT),
    .P_CNT_W   (P_CNT_W)
  ) u_md (
    .clk    (clk),
    .reset  (reset),
    .i_start(i_e_md_start),
    .i_op   (i_e_md_op),
    .i_req  (w_req),
    .o_busy (w_busy)
  );
  // The M stage holds a flushed bubble in EXC_HOLD, so exc/eret seen there are stale.
  always_comb begin
    w_req  = ~reset & (r_state == RUN) & i_m_exc;
    w_eret = ~reset & (r_state == RUN) & i_m_eret & ~w_req;
    w_next = w_req ? EXC_HOLD : RUN;
    w_hz   = hz_src(i_d_rs, i_d_tuse_rs, i_e_a3, i_e_tnew, i_m_a3, i_m_tnew)
           | hz_src(i_d_rt, i_d_tuse_rt, i_e_a3, i_e_tnew, i_m_a3, i_m_tnew)
           | (i_d_is_md & (w_busy | i_e_md_start));
    o_req         = w_req;
    o_eret_flush  = w_eret;
    o_stall       = ~reset & w_hz & ~w_req & ~w_eret;
    o_npc_sel     = w_req ? NPC_HANDLER : w_eret ? NPC_EPC : NPC_NORMAL;
    o_redirect_pc = w_req ? P_HANDLER_PC : w_eret ? i_epc : 32'd0;
    o_md_busy     = ~reset & w_busy;
  end
endmodule

// File: tb/tb_pipe_flow_ctrl.sv
// tb_pipe_flow_ctrl: directed stimulus, per-cycle behavioural model compare plus literal checks
module tb_pipe_flow_ctrl;
  logic clk = 1'b0;
  logic reset;
  logic [4:0] d_rs, d_rt, e_a3, m_a3;
  logic [1:0] d_tuse_rs, d_tuse_rt, e_tnew, m_tnew;
  logic d_is_md, e_md_start, e_md_op, m_exc, m_eret;
  logic [31:0] epc;
  logic stall, req, eret_flush, md_busy;
  logic [1:0] npc_sel;
  logic [31:0] redirect_pc;
  int checks = 0, errors = 0;
  int m_left = 0, n_left = 0;
  bit m_hold = 0, n_hold = 0;

  always #5 clk = ~clk;

  pipe_flow_ctrl dut (
    .clk(clk), .reset(reset),
    .i_d_rs(d_rs), .i_d_rt(d_rt), .i_d_tuse_rs(d_tuse_rs), .i_d_tuse_rt(d_tuse_rt),
    .i_d_is_md(d_is_md), .i_e_a3(e_a3), .i_e_tnew(e_tnew), .i_m_a3(m_a3), .i_m_tnew(m_tnew),
    .i_e_md_start(e_md_start), .i_e_md_op(e_md_op), .i_m_exc(m_exc), .i_m_eret(m_eret),
    .i_epc(epc), .o_stall(stall), .o_req(req), .o_eret_flush(eret_flush),
    .o_npc_sel(npc_sel), .o_redirect_pc(redirect_pc), .o_md_busy(md_busy)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%h want=%h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit src_hz(input int d, input int tuse);
    return d != 0 && ((d == int'(e_a3) && int'(e_tnew) > tuse) || (d == int'(m_a3) && int'(m_tnew) > tuse));
  endfunction

  // Model: outputs follow from the rules, with only "cycles of busy left" and "last cycle took req" as memory.
  always @(negedge clk) begin
    bit x_req, x_eret, x_busy, x_stall;
    int x_sel;
    logic [31:0] x_pc;
    if (reset) begin
      x_req = 0; x_eret = 0; x_busy = 0; x_stall = 0; x_sel = 0; x_pc = 0;
      n_left = 0; n_hold = 0;
    end else begin
      x_req  = !m_hold && m_exc;
      x_eret = !m_hold && m_eret && !x_req;
      x_busy = m_left > 0;
      x_stall = (src_hz(int'(d_rs), int'(d_tuse_rs)) || src_hz(int'(d_rt), int'(d_tuse_rt))
                 || (d_is_md && (x_busy || e_md_start))) && !x_req && !x_eret;
      x_sel = x_req ? 1 : x_eret ? 2 : 0;
      x_pc  = x_req ? 32'h4180 : x_eret ? epc : 32'd0;
      n_left = (e_md_start && !x_req && m_left == 0) ? (e_md_op ? 10 : 5) : (m_left > 0 ? m_left - 1 : 0);
      n_hold = x_req;
    end
    chk("m_req", {31'd0, req}, {31'd0, x_req});
    chk("m_eret", {31'd0, eret_flush}, {31'd0, x_eret});
    chk("m_stall", {31'd0, stall}, {31'd0, x_stall});
    chk("m_busy", {31'd0, md_busy}, {31'd0, x_busy});
    chk("m_npc", {30'd0, npc_sel}, x_sel);
    chk("m_pc", redirect_pc, x_pc);
  end

  always @(posedge clk) begin
    m_left = n_left;
    m_hold = n_hold;
  end

  task automatic clr();
    d_rs = 0; d_rt = 0; d_tuse_rs = 3; d_tuse_rt = 3; d_is_md = 0;
    e_a3 = 0; e_tnew = 0; m_a3 = 0; m_tnew = 0;
    e_md_start = 0; e_md_op = 0; m_exc = 0; m_eret = 0; epc = 0;
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int nb;
    reset = 1; clr();
    m_exc = 1; m_eret = 1; d_is_md = 1; e_a3 = 5; e_tnew = 2; d_rs = 5; d_tuse_rs = 0;
    @(negedge clk); chk("rst_req", {31'd0, req}, 0); chk("rst_stall", {31'd0, stall}, 0);
    cyc();
    @(negedge clk); chk("rst_pc", redirect_pc, 0); chk("rst_npc", {30'd0, npc_sel}, 0);
    cyc(); reset = 0; clr();
    e_a3 = 5; e_tnew = 2; d_rs = 5; d_tuse_rs = 0;
    @(negedge clk); chk("lu_stall", {31'd0, stall}, 1);
    cyc(); d_rs = 0;
    @(negedge clk); chk("lu_r0", {31'd0, stall}, 0);
    cyc(); clr(); m_a3 = 7; m_tnew = 1; d_rt = 7; d_tuse_rt = 0;
    @(negedge clk); chk("m_hz_stall", {31'd0, stall}, 1);
    cyc(); d_tuse_rt = 1;
    @(negedge clk); chk("m_hz_eq", {31'd0, stall}, 0);
    cyc(); clr();
    e_md_start = 1; e_md_op = 0; d_is_md = 1;
    @(negedge clk); chk("mul_start_stall", {31'd0, stall}, 1); chk("mul_start_busy", {31'd0, md_busy}, 0);
    cyc(); e_md_start = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk); chk("mul_busy", {31'd0, md_busy}, 1); chk("mul_stall", {31'd0, stall}, 1);
      cyc();
    end
    @(negedge clk); chk("mul_done_busy", {31'd0, md_busy}, 0); chk("mul_done_stall", {31'd0, stall}, 0);
    cyc(); clr();
    e_a3 = 5; e_tnew = 2; d_rs = 5; d_tuse_rs = 0; m_exc = 1;
    @(negedge clk);
    chk("exc_req", {31'd0, req}, 1); chk("exc_stall", {31'd0, stall}, 0);
    chk("exc_npc", {30'd0, npc_sel}, 1); chk("exc_pc", redirect_pc, 32'h4180);
    cyc();
    @(negedge clk); chk("hold_req", {31'd0, req}, 0); chk("hold_stall", {31'd0, stall}, 1);
    cyc(); clr();
    m_eret = 1; epc = 32'h0000_3010;
    @(negedge clk);
    chk("eret_fl", {31'd0, eret_flush}, 1); chk("eret_npc", {30'd0, npc_sel}, 2); chk("eret_pc", redirect_pc, 32'h3010);
    cyc(); m_exc = 1;
    @(negedge clk);
    chk("both_req", {31'd0, req}, 1); chk("both_eret", {31'd0, eret_flush}, 0); chk("both_pc", redirect_pc, 32'h4180);
    cyc(); m_exc = 0;
    @(negedge clk); chk("hold_eret", {31'd0, eret_flush}, 0); chk("hold_npc", {30'd0, npc_sel}, 0);
    cyc(); clr();
    m_exc = 1; e_md_start = 1; e_md_op = 1;
    @(negedge clk); chk("divreq_req", {31'd0, req}, 1);
    cyc(); clr();
    @(negedge clk); chk("divreq_busy", {31'd0, md_busy}, 0);
    cyc();
    e_md_start = 1; e_md_op = 1;
    @(negedge clk);
    cyc(); e_md_start = 0; nb = 0;
    for (int i = 0; i < 12; i++) begin
      m_exc = (i == 2);
      @(negedge clk); if (md_busy) nb++;
      cyc();
    end
    chk("div_len", nb, 10);
    clr(); e_md_start = 1; e_md_op = 1;
    @(negedge clk);
    cyc(); e_md_start = 0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk); cyc();
    end
    @(negedge clk); chk("pre_rst_busy", {31'd0, md_busy}, 1);
    cyc();
    reset = 1; m_exc = 1; m_eret = 1; d_is_md = 1; epc = 32'h3010; e_a3 = 5; e_tnew = 2; d_rs = 5; d_tuse_rs = 0;
    @(negedge clk);
    chk("rd_busy", {31'd0, md_busy}, 0); chk("rd_req", {31'd0, req}, 0);
    chk("rd_stall", {31'd0, stall}, 0); chk("rd_eret", {31'd0, eret_flush}, 0);
    cyc();
    @(negedge clk); chk("rd2_busy", {31'd0, md_busy}, 0);
    cyc(); reset = 0; clr(); m_exc = 1;
    @(negedge clk); chk("post_rst_req", {31'd0, req}, 1); chk("post_rst_busy", {31'd0, md_busy}, 0);
    cyc(); clr();
    @(negedge clk);
    cyc();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
